// File: rtl/pc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pc_pkg
// Purpose  : Shared types and default constants for the PC-select unit.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package pc_pkg;

  // Encoded so that a plain numeric compare gives source priority.
  typedef enum logic [1:0] {
    SRC_SEQ    = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JUMP   = 2'd2,
    SRC_TRAP   = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    HOLD      = 2'd2,
    HOLD_PEND = 2'd3
  } pc_state_t;

  localparam logic [31:0] PC_DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned PC_DEFAULT_INC          = 4;

endpackage
`default_nettype wire

// File: rtl/pc_select_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pc_select_unit_if
// Purpose  : Redirect inputs and fetch-address outputs of the PC-select unit.
//            master = control/branch side, slave = pc_select_unit.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface pc_select_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             STALL;
  logic             BRANCH_TAKEN;
  logic [WIDTH-1:0] BRANCH_TARGET;
  logic             JUMP;
  logic [WIDTH-1:0] JUMP_TARGET;
  logic             TRAP;
  logic [WIDTH-1:0] TRAP_VECTOR;
  logic             CALL;
  logic             RET;
  logic [WIDTH-1:0] PC;
  logic             PC_VALID;
  logic             REDIRECT;

  modport master (
    output STALL, BRANCH_TAKEN, BRANCH_TARGET, JUMP, JUMP_TARGET,
           TRAP, TRAP_VECTOR, CALL, RET,
    input  PC, PC_VALID, REDIRECT
  );

  modport slave (
    input  STALL, BRANCH_TAKEN, BRANCH_TARGET, JUMP, JUMP_TARGET,
           TRAP, TRAP_VECTOR, CALL, RET,
    output PC, PC_VALID, REDIRECT
  );
endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pc_ras
// Purpose  : Circular return-address stack. A push when full overwrites the
//            oldest entry; the occupancy count saturates at RAS_DEPTH.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module pc_ras #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] C_FULL = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == C_FULL);
  assign top_o   = mem_q[wr_ptr_q - PW'(1)];

  // Pointer and occupancy: push wins over pop, pop on empty is ignored.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (push_i) begin
      wr_ptr_q <= wr_ptr_q + PW'(1);
      if (!full_o) count_q <= count_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      wr_ptr_q <= wr_ptr_q - PW'(1);
      count_q  <= count_q - CW'(1);
    end
  end

  // Entry storage; contents are meaningless while the count is zero.
  always_ff @(posedge CLK) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule
`default_nettype wire

// File: rtl/pc_select_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pc_select_unit
// Purpose  : Program-counter register with prioritised next-PC selection
//            (TRAP > JUMP > BRANCH > sequential), stall hold and a one-entry
//            buffer for redirects arriving during a stall.
//            Optional return-address stack enabled by macro PC_RAS_EN.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module pc_select_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_DEFAULT_RESET_VECTOR),
  parameter int unsigned      INC          = PC_DEFAULT_INC,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  pc_select_unit_if.slave  bus
);
  localparam logic [WIDTH-1:0] C_INC = WIDTH'(INC);

  pc_state_t        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             redirect_q, redirect_d;
  pc_src_t          pend_src_q, pend_src_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_call_q, pend_call_d;
  logic             pend_ret_q, pend_ret_d;

  pc_src_t          live_src, sel_src;
  logic [WIDTH-1:0] live_tgt, sel_tgt, next_tgt, pc_inc;
  logic             live_call, live_ret, sel_call, sel_ret, ret_hit;
  logic             apply_en, ras_push, ras_pop, ras_empty;
  logic [WIDTH-1:0] ras_top;

  assign pc_inc = pc_q + C_INC;

`ifdef PC_RAS_EN
  logic ras_full_unused;
  assign live_call = bus.JUMP & ~bus.TRAP & bus.CALL;
  assign live_ret  = bus.JUMP & ~bus.TRAP & bus.RET;

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK         (CLK),
    .RESET       (RESET),
    .push_i      (ras_push),
    .push_data_i (pc_inc),
    .pop_i       (ras_pop),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (ras_full_unused)
  );
`else
  localparam int unsigned C_RAS_DEPTH_UNUSED = RAS_DEPTH;
  logic ras_unused;
  assign live_call  = 1'b0;
  assign live_ret   = 1'b0;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_unused = ^{bus.CALL, bus.RET, ras_push, ras_pop};
`endif

  // Highest-priority redirect presented this cycle.
  always_comb begin
    live_src = SRC_SEQ;
    live_tgt = bus.BRANCH_TARGET;
    if (bus.TRAP) begin
      live_src = SRC_TRAP;
      live_tgt = bus.TRAP_VECTOR;
    end else if (bus.JUMP) begin
      live_src = SRC_JUMP;
      live_tgt = bus.JUMP_TARGET;
    end else if (bus.BRANCH_TAKEN) begin
      live_src = SRC_BRANCH;
      live_tgt = bus.BRANCH_TARGET;
    end
  end

  // Pending vs live arbitration (ties go to live) and stack side effects.
  always_comb begin
    sel_src  = live_src;
    sel_tgt  = live_tgt;
    sel_call = live_call;
    sel_ret  = live_ret;
    if (state_q == HOLD_PEND && pend_src_q > live_src) begin
      sel_src  = pend_src_q;
      sel_tgt  = pend_tgt_q;
      sel_call = pend_call_q;
      sel_ret  = pend_ret_q;
    end
    ret_hit  = (sel_src == SRC_JUMP) && sel_ret && !sel_call && !ras_empty;
    next_tgt = ret_hit ? ras_top : sel_tgt;
    apply_en = (state_q != BOOT) && !bus.STALL;
    ras_push = apply_en && (sel_src == SRC_JUMP) && sel_call;
    ras_pop  = apply_en && ret_hit;
  end

  // Next-state and next-PC decision.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    redirect_d  = 1'b0;
    pend_src_d  = pend_src_q;
    pend_tgt_d  = pend_tgt_q;
    pend_call_d = pend_call_q;
    pend_ret_d  = pend_ret_q;
    case (state_q)
      BOOT: begin
        valid_d = 1'b1;
        state_d = RUN;
      end
      RUN, HOLD, HOLD_PEND: begin
        if (!bus.STALL) begin
          pc_d        = (sel_src != SRC_SEQ) ? next_tgt : pc_inc;
          redirect_d  = (sel_src != SRC_SEQ);
          pend_src_d  = SRC_SEQ;
          pend_call_d = 1'b0;
          pend_ret_d  = 1'b0;
          state_d     = RUN;
        end else if (live_src != SRC_SEQ &&
                     (state_q != HOLD_PEND || live_src >= pend_src_q)) begin
          pend_src_d  = live_src;
          pend_tgt_d  = live_tgt;
          pend_call_d = live_call;
          pend_ret_d  = live_ret;
          state_d     = HOLD_PEND;
        end else if (state_q != HOLD_PEND) begin
          state_d = HOLD;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State and PC registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      valid_q     <= 1'b0;
      redirect_q  <= 1'b0;
      pend_src_q  <= SRC_SEQ;
      pend_tgt_q  <= '0;
      pend_call_q <= 1'b0;
      pend_ret_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      redirect_q  <= redirect_d;
      pend_src_q  <= pend_src_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_call_q <= pend_call_d;
      pend_ret_q  <= pend_ret_d;
    end
  end

  assign bus.PC       = pc_q;
  assign bus.PC_VALID = valid_q;
  assign bus.REDIRECT = redirect_q;
endmodule
`default_nettype wire

// File: tb/tb_pc_select_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_pc_select_unit
// Purpose  : Self-checking bench: directed vector table, hand-written reset
//            and stack sequences, randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_pc_select_unit;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        tr;
    logic [31:0] tv;
    logic        call;
    logic        ret;
  } in_t;

  typedef struct {
    in_t         in;
    logic [31:0] pc;
    logic        red;
  } vec_t;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;

  pc_select_unit_if #(.WIDTH(32)) u_bus ();

  pc_select_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0000_0000),
    .INC          (4),
    .RAS_DEPTH    (4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (u_bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: architectural PC, one pending redirect slot, stack queue.
  logic [31:0] m_pc;
  logic        m_valid, m_red, m_boot;
  logic        m_pv, m_pcall, m_pret;
  int          m_pp;
  logic [31:0] m_pt;
  logic [31:0] m_ras[$];

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_red = 1'b0; m_boot = 1'b0;
    m_pv = 1'b0; m_pp = 0; m_pt = 32'h0; m_pcall = 1'b0; m_pret = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_edge(in_t x);
    int          lp, p;
    logic [31:0] lt, t;
    logic        c, r;
    if (!m_boot) begin
      m_boot = 1'b1; m_valid = 1'b1; m_red = 1'b0;
      return;
    end
    lp = x.tr ? 3 : x.j ? 2 : x.br ? 1 : 0;
    lt = x.tr ? x.tv : x.j ? x.jt : x.bt;
    if (x.stall) begin
      m_red = 1'b0;
      if (lp > 0 && (!m_pv || lp >= m_pp)) begin
        m_pv = 1'b1; m_pp = lp; m_pt = lt; m_pcall = x.call; m_pret = x.ret;
      end
    end else begin
      if (m_pv && m_pp > lp) begin
        p = m_pp; t = m_pt; c = m_pcall; r = m_pret;
      end else begin
        p = lp; t = lt; c = x.call; r = x.ret;
      end
      if (p == 0) begin
        m_pc = m_pc + 32'd4; m_red = 1'b0;
      end else begin
`ifdef PC_RAS_EN
        if (p == 2 && c) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end else if (p == 2 && r && m_ras.size() > 0) begin
          t = m_ras.pop_back();
        end
`else
        c = c; r = r;
`endif
        m_pc = t; m_red = 1'b1;
      end
      m_pv = 1'b0;
    end
  endtask

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  function automatic in_t mk_in(logic stall, logic br, logic [31:0] bt,
                                logic j, logic [31:0] jt, logic tr,
                                logic [31:0] tv, logic call, logic ret);
    in_t x;
    x.stall = stall; x.br = br; x.bt = bt; x.j = j; x.jt = jt;
    x.tr = tr; x.tv = tv; x.call = call; x.ret = ret;
    return x;
  endfunction

  function automatic vec_t mk(logic stall, logic br, logic [31:0] bt, logic j,
                              logic [31:0] jt, logic tr, logic [31:0] tv,
                              logic [31:0] pc, logic red);
    vec_t v;
    v.in = mk_in(stall, br, bt, j, jt, tr, tv, 1'b0, 1'b0);
    v.pc = pc; v.red = red;
    return v;
  endfunction

  task automatic drive(in_t x);
    u_bus.STALL = x.stall;  u_bus.BRANCH_TAKEN = x.br; u_bus.BRANCH_TARGET = x.bt;
    u_bus.JUMP  = x.j;      u_bus.JUMP_TARGET  = x.jt; u_bus.TRAP = x.tr;
    u_bus.TRAP_VECTOR = x.tv; u_bus.CALL = x.call;     u_bus.RET = x.ret;
  endtask

  // One clock with model comparison.
  task automatic cyc(in_t x);
    drive(x);
    @(posedge CLK); #1;
    model_edge(x);
    chk("model_pc", u_bus.PC, m_pc);
    chk("model_valid", {31'b0, u_bus.PC_VALID}, {31'b0, m_valid});
    chk("model_redirect", {31'b0, u_bus.REDIRECT}, {31'b0, m_red});
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 RESET = 1'b0;
    #1;
    model_reset();
    chk("reset_pc", u_bus.PC, 32'h0);
    chk("reset_valid", {31'b0, u_bus.PC_VALID}, 32'h0);
    chk("reset_redirect", {31'b0, u_bus.REDIRECT}, 32'h0);
    @(posedge CLK); #3;
    RESET = 1'b1;
  endtask

  vec_t vecs[$];
  in_t  idle;

  initial begin
    idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    model_reset();
    #1;
    chk("por_pc", u_bus.PC, 32'h0);
    chk("por_valid", {31'b0, u_bus.PC_VALID}, 32'h0);
    chk("por_redirect", {31'b0, u_bus.REDIRECT}, 32'h0);
    @(posedge CLK); #3;
    RESET = 1'b1;

    //         stall br bt       j  jt            tr tv        pc            red
    vecs.push_back(mk(0, 0, 0,       0, 0,            0, 0,        32'h0,        0)); // boot
    vecs.push_back(mk(0, 0, 0,       0, 0,            0, 0,        32'h4,        0));
    vecs.push_back(mk(0, 0, 0,       0, 0,            0, 0,        32'h8,        0));
    vecs.push_back(mk(0, 0, 0,       0, 0,            0, 0,        32'hC,        0));
    vecs.push_back(mk(0, 0, 0,       0, 0,            0, 0,        32'h10,       0));
    vecs.push_back(mk(0, 1, 32'h100, 1, 32'h200,      1, 32'h80,   32'h80,       1));
    vecs.push_back(mk(0, 0, 0,       0, 0,            0, 0,        32'h84,       0));
    vecs.push_back(mk(1, 1, 32'h40,  0, 0,            0, 0,        32'h84,       0));
    vecs.push_back(mk(1, 0, 0,       1, 32'h60,       0, 0,        32'h84,       0));
    vecs.push_back(mk(1, 0, 0,       0, 0,            0, 0,        32'h84,       0));
    vecs.push_back(mk(0, 0, 0,       0, 0,            0, 0,        32'h60,       1));
    vecs.push_back(mk(1, 0, 0,       1, 32'h60,       0, 0,        32'h60,       0));
    vecs.push_back(mk(0, 1, 32'h90,  0, 0,            0, 0,        32'h60,       1));
    vecs.push_back(mk(0, 0, 0,       0, 0,            0, 0,        32'h64,       0));
    vecs.push_back(mk(0, 0, 0,       1, 32'hFFFFFFF8, 0, 0,        32'hFFFFFFF8, 1));
    vecs.push_back(mk(0, 0, 0,       0, 0,            0, 0,        32'hFFFFFFFC, 0));
    vecs.push_back(mk(0, 0, 0,       0, 0,            0, 0,        32'h0,        0)); // wrap
    vecs.push_back(mk(1, 1, 32'h200, 0, 0,            0, 0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0,       0, 0,            1, 32'h300,  32'h0,        0));
    vecs.push_back(mk(0, 0, 0,       1, 32'h400,      0, 0,        32'h300,      1));
    vecs.push_back(mk(1, 0, 0,       0, 0,            1, 32'h500,  32'h300,      0));
    vecs.push_back(mk(0, 0, 0,       0, 0,            1, 32'h600,  32'h600,      1)); // tie: live
    vecs.push_back(mk(0, 0, 0,       0, 0,            0, 0,        32'h604,      0));
    vecs.push_back(mk(1, 0, 0,       1, 32'h700,      0, 0,        32'h604,      0));
    vecs.push_back(mk(1, 1, 32'h800, 0, 0,            0, 0,        32'h604,      0)); // dropped
    vecs.push_back(mk(0, 0, 0,       0, 0,            0, 0,        32'h700,      1));
    vecs.push_back(mk(0, 0, 0,       0, 0,            0, 0,        32'h704,      0));

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      @(posedge CLK); #1;
      model_edge(vecs[i].in);
      chk($sformatf("vec%0d_pc", i), u_bus.PC, vecs[i].pc);
      chk($sformatf("vec%0d_valid", i), {31'b0, u_bus.PC_VALID}, 32'h1);
      chk($sformatf("vec%0d_redirect", i), {31'b0, u_bus.REDIRECT}, {31'b0, vecs[i].red});
    end
    drive(idle);

    // Reset while stalled with a captured redirect discards it.
    cyc(mk_in(1, 1, 32'h440, 0, 0, 0, 0, 0, 0));
    do_reset();
    cyc(idle);
    chk("rst_boot_pc", u_bus.PC, 32'h0);
    cyc(idle);
    chk("rst_after_pc", u_bus.PC, 32'h4);
    chk("rst_after_redirect", {31'b0, u_bus.REDIRECT}, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      in_t x;
      x.stall = ($urandom_range(0, 2) == 0);
      x.br    = ($urandom_range(0, 3) == 0);
      x.bt    = $urandom & 32'hFFFF_FFFC;
      x.j     = ($urandom_range(0, 3) == 0);
      x.jt    = $urandom & 32'hFFFF_FFFC;
      x.tr    = ($urandom_range(0, 7) == 0);
      x.tv    = $urandom & 32'hFFFF_FFFC;
      x.call  = ($urandom_range(0, 2) == 0);
      x.ret   = ($urandom_range(0, 2) == 0);
      cyc(x);
    end

`ifdef PC_RAS_EN
    do_reset();
    cyc(idle);
    for (int k = 0; k < 20 && m_pc != 32'h20; k++) cyc(idle);
    chk("ras_start_pc", u_bus.PC, 32'h20);
    cyc(mk_in(0, 0, 0, 1, 32'h100, 0, 0, 1, 0));
    chk("ras_call_pc", u_bus.PC, 32'h100);
    cyc(mk_in(0, 0, 0, 1, 32'h999, 0, 0, 0, 1));
    chk("ras_ret_pc", u_bus.PC, 32'h24);
    for (int k = 0; k < 5; k++) cyc(mk_in(0, 0, 0, 1, 32'h1000 + k * 32'h10, 0, 0, 1, 0));
    for (int k = 0; k < 5; k++) cyc(mk_in(0, 0, 0, 1, 32'hABC0, 0, 0, 0, 1));
    chk("ras_fifth_ret_pc", u_bus.PC, 32'hABC0);
    cyc(mk_in(0, 0, 0, 1, 32'h2000, 0, 0, 1, 0));
    do_reset();
    cyc(idle);
    cyc(mk_in(0, 0, 0, 1, 32'h3000, 0, 0, 0, 1));
    chk("ras_after_reset_pc", u_bus.PC, 32'h3000);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_select_unit.md
Name: pc_select_unit

Overview:
- Parametrised successor to the processor's PC-select multiplexer.
- Owns the program-counter register and selects the next PC from four sources: sequential increment, taken branch, jump and trap vector, resolved by fixed priority.
- Holds the PC during pipeline stalls and buffers any redirect that arrives while stalled.
- Sits between the control unit/ALU branch logic and instruction memory; drives the fetch address and a flush pulse.

Parameters:
- WIDTH, 32, PC and target width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value while in reset and on first fetch.
- INC, 4, sequential increment added to the PC.
- RAS_DEPTH, 4, return-address-stack entries, power of 2 (used only with PC_RAS_EN).

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset.
- STALL  in  1  hold PC this cycle.
- BRANCH_TAKEN  in  1  single-cycle pulse, branch resolved taken.
- BRANCH_TARGET  in  WIDTH  branch destination.
- JUMP  in  1  single-cycle pulse, unconditional jump.
- JUMP_TARGET  in  WIDTH  jump destination.
- TRAP  in  1  single-cycle pulse, exception.
- TRAP_VECTOR  in  WIDTH  exception handler address.
- CALL  in  1  qualifies JUMP as a call (PC_RAS_EN only).
- RET  in  1  qualifies JUMP as a return (PC_RAS_EN only).
- PC  out  WIDTH  registered fetch address.
- PC_VALID  out  1  PC is a valid fetch address.
- REDIRECT  out  1  registered one-cycle pulse; PC was just loaded from a non-sequential source.

Behaviour:
- Reset (RESET=0, asynchronous):
  - PC=RESET_VECTOR, PC_VALID=0, REDIRECT=0.
  - Pending buffer cleared; FSM enters BOOT.
  - Reset mid-stall or with a pending redirect discards everything.
- Source priority: TRAP > JUMP > BRANCH_TAKEN > sequential. Lower-priority simultaneous pulses are dropped.
- FSM states and transitions:
  - BOOT: first edge after RESET deasserts → PC_VALID<=1, PC unchanged (reset vector fetched), go to RUN.
  - RUN, STALL=0: PC<=highest-priority live target, else PC+INC. REDIRECT<=1 if a target was taken, else 0.
  - RUN, STALL=1: PC held, REDIRECT<=0. A live redirect is captured into the pending buffer (target plus source) → HOLD_PEND; otherwise → HOLD.
  - HOLD, STALL=1: PC held. A live redirect → HOLD_PEND.
  - HOLD, STALL=0: behaves as RUN with STALL=0 → RUN.
  - HOLD_PEND, STALL=1: a live redirect of priority ≥ pending replaces the pending entry; a lower-priority one is dropped.
  - HOLD_PEND, STALL=0: PC<=winner of pending vs live. Ties go to live; higher priority wins. REDIRECT<=1, buffer cleared → RUN.
- Latency: a redirect appears on PC one edge after it is applied (unstalled); REDIRECT is aligned with the new PC.
- Arithmetic: PC+INC is modulo 2^WIDTH; all-ones-region wrap to low addresses is legal, with no flag.
- Targets are used unmodified; no alignment check.
- PC_VALID stays 1 from BOOT exit until reset.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: a RAS_DEPTH-entry circular return-address stack is instantiated.
  - JUMP&CALL applied: pushes PC+INC.
  - JUMP&RET applied, stack non-empty: target is top-of-stack (replaces JUMP_TARGET), then pops.
  - RET with empty stack: falls back to JUMP_TARGET.
  - Push when full: overwrites the oldest entry, count saturates.
  - Push/pop take effect only when the jump is actually applied (not while pending). A TRAP overriding the jump cancels the push/pop.
  - Reset empties the stack.
- Undefined: CALL/RET ports remain but are ignored; no stack storage.

Decomposition:
- Shared package pc_pkg:
  - pc_src_t enum: SRC_SEQ, SRC_BRANCH, SRC_JUMP, SRC_TRAP, ordered so numeric compare gives priority.
  - pc_state_t enum: BOOT, RUN, HOLD, HOLD_PEND.
  - Default RESET_VECTOR and INC constants.
- One sub-module: pc_ras (push/pop/top/empty/full, parametrised WIDTH, RAS_DEPTH), instantiated only under PC_RAS_EN.

Test Plan:
- Reset release, STALL=0 → PC=0 with PC_VALID=0; next edge PC_VALID=1, PC=0; then 4, 8, 12 on successive edges; REDIRECT=0.
- PC=0x10, BRANCH_TAKEN+JUMP+TRAP together (0x100/0x200/0x80) → next PC=0x80, REDIRECT=1 for exactly one cycle, then 0x84.
- STALL=1 for 3 cycles with BRANCH_TAKEN (0x40) in cycle 1 and JUMP (0x60) in cycle 2, STALL drops → PC held, then PC=0x60, REDIRECT=1.
- HOLD_PEND with pending JUMP 0x60, BRANCH_TAKEN 0x90 live on the release cycle → PC=0x60; branch dropped.
- WIDTH=32, PC=0xFFFF_FFFC, STALL=0 → next PC=0x0000_0000, no redirect.
- PC_RAS_EN, RAS_DEPTH=4:
  - JUMP+CALL at PC=0x20 to 0x100 → stack top 0x24.
  - Later JUMP+RET → PC=0x24.
  - Five calls then five returns → the fifth return uses JUMP_TARGET.
  - Async reset mid-stream → stack empty.
